// File: rtl/uart_hex_collector.sv
// Collects ASCII hex digits from a UART byte stream into a 24-bit display word.
// Optional idle timeout on partial lines is enabled by defining UART_HEX_TIMEOUT_EN.
module uart_hex_collector #(
  parameter int unsigned MAX_DIGITS = 6
`ifdef UART_HEX_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 50_000_000
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [23:0] data_out,
  output logic        data_update,
  output logic        err,
  output logic [2:0]  digit_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  localparam logic [2:0] DIGIT_LIMIT = 3'(MAX_DIGITS);

  // Returns {is_hex, nibble}; letters map through their low nibble plus 9.
  function automatic logic [4:0] decode_hex(input logic [7:0] c);
    logic [4:0] r;
    if ((c >= 8'h30) && (c <= 8'h39)) begin
      r = {1'b1, c[3:0]};
    end else if (((c >= 8'h41) && (c <= 8'h46)) || ((c >= 8'h61) && (c <= 8'h66))) begin
      r = {1'b1, c[3:0] + 4'd9};
    end else begin
      r = 5'd0;
    end
    return r;
  endfunction

  function automatic logic is_term(input logic [7:0] c);
    return (c == 8'h0D) || (c == 8'h0A);
  endfunction

  state_e      state_q, state_d;
  logic        rx_valid_q;
  logic [7:0]  rx_data_q;
  logic [23:0] shadow_q, shadow_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [23:0] data_q, data_d;
  logic        upd_q, upd_d;
  logic        err_q, err_d;

  logic [4:0]  dec_s;
  logic        byte_hex_s;
  logic        byte_term_s;
  logic [3:0]  nib_s;
  logic        tmo_expire_s;

  assign dec_s       = decode_hex(rx_data_q);
  assign byte_hex_s  = dec_s[4];
  assign nib_s       = dec_s[3:0];
  assign byte_term_s = is_term(rx_data_q);

`ifdef UART_HEX_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Any byte restarts the idle count, so a byte landing on the expiry cycle wins.
  always_comb begin : p_timeout
    tmo_d        = '0;
    tmo_expire_s = 1'b0;
    if (rx_valid_q) begin
      tmo_d = '0;
    end else if ((state_q == ST_COLLECT) || (state_q == ST_DISCARD)) begin
      if (tmo_q == TMO_LAST) begin
        tmo_d        = '0;
        tmo_expire_s = 1'b1;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end else begin
      tmo_d = '0;
    end
  end
`else
  assign tmo_expire_s = 1'b0;
`endif

  // Input bytes are registered first; the parser works one cycle behind the strobe.
  always_ff @(posedge clk) begin : p_regs
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'h00;
      shadow_q   <= 24'h000000;
      cnt_q      <= 3'd0;
      data_q     <= 24'h000000;
      upd_q      <= 1'b0;
      err_q      <= 1'b0;
`ifdef UART_HEX_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rx_valid_q <= rx_valid;
      rx_data_q  <= rx_data;
      shadow_q   <= shadow_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      upd_q      <= upd_d;
      err_q      <= err_d;
`ifdef UART_HEX_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  always_comb begin : p_next_state
    state_d = state_q;
    if (tmo_expire_s) begin
      state_d = ST_IDLE;
    end else if (rx_valid_q) begin
      case (state_q)
        ST_IDLE: begin
          if (byte_hex_s) begin
            state_d = ST_COLLECT;
          end else if (byte_term_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DISCARD;
          end
        end
        ST_COLLECT: begin
          if (byte_hex_s) begin
            state_d = (cnt_q == DIGIT_LIMIT) ? ST_DISCARD : ST_COLLECT;
          end else if (byte_term_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DISCARD;
          end
        end
        ST_DISCARD: begin
          if (byte_term_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DISCARD;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  always_comb begin : p_outputs
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    upd_d    = 1'b0;
    err_d    = 1'b0;
    if (tmo_expire_s) begin
      shadow_d = 24'h000000;
      cnt_d    = 3'd0;
      err_d    = 1'b1;
    end else if (rx_valid_q) begin
      case (state_q)
        ST_IDLE: begin
          if (byte_hex_s) begin
            shadow_d = {20'h00000, nib_s};
            cnt_d    = 3'd1;
          end else if (byte_term_s) begin
            cnt_d    = 3'd0;
          end else begin
            err_d    = 1'b1;
          end
        end
        ST_COLLECT: begin
          if (byte_hex_s && (cnt_q != DIGIT_LIMIT)) begin
            shadow_d = {shadow_q[19:0], nib_s};
            cnt_d    = cnt_q + 3'd1;
          end else if (byte_term_s) begin
            data_d   = shadow_q;
            upd_d    = 1'b1;
            shadow_d = 24'h000000;
            cnt_d    = 3'd0;
          end else begin
            // Covers both the seventh digit and any non-hex character.
            err_d    = 1'b1;
            shadow_d = 24'h000000;
            cnt_d    = 3'd0;
          end
        end
        ST_DISCARD: begin
          if (byte_term_s) begin
            shadow_d = 24'h000000;
            cnt_d    = 3'd0;
          end else begin
            cnt_d    = 3'd0;
          end
        end
        default: begin
          shadow_d = 24'h000000;
          cnt_d    = 3'd0;
        end
      endcase
    end else begin
      upd_d = 1'b0;
    end
  end

  assign data_out    = data_q;
  assign data_update = upd_q;
  assign err         = err_q;
  assign digit_cnt   = cnt_q;

endmodule
